// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, default frame
// geometry and the baud divider calculation reused by the future transmitter.
package uart_rx_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int N_TICKS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Rounded clock divider so the oversampling tick lands closest to the target rate.
    function automatic int baud_div(input int clk_freq, input int baud, input int n_ticks);
        int den;
        den = baud * n_ticks;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running oversampling tick generator: one-cycle pulse every DIV clocks.
// Never resynchronised to line activity; shared by receiver and transmitter.
module baud_rate_gen
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 19200,
    parameter int N_TICKS  = N_TICKS_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD, N_TICKS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: synchronises the RX pin, samples each bit mid-period
// from the oversampling tick, and hands on only correctly framed bytes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int N_TICKS  = N_TICKS_DEF,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 19200
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    localparam int SW = $clog2(N_TICKS);
    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(N_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

    logic               tick;
    logic [1:0]         sync_q;
    logic               rx_s;
    rx_state_e          state_q;
    logic [SW-1:0]      s_q;
    logic [NW-1:0]      n_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_DATA-1:0] data_q;
    logic               done_q;
    logic               ferr_q;

    baud_rate_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .N_TICKS  (N_TICKS)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    // NOTE: the synchroniser resets to the idle (high) level; resetting it to 0
    // would present a false start edge to the FSM right after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            // Pulses default low every cycle so each fires for exactly one clock.
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s_q == S_MID) begin
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            b_q <= {rx_s, b_q[NB_DATA-1:1]};
                            if (n_q == N_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            if (rx_s) begin
                                data_q  <= b_q;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= ST_BREAK;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    // A held-low line must return high before a new start is accepted.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV = 10 (160 clocks per bit): good frames,
// back-to-back, glitch, framing error with break, mid-frame reset, baud skew.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BIT_CYC = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       done;
    logic       ferr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int last_done_cyc = 0;
    int edge_cyc = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .NB_DATA  (8),
        .N_TICKS  (16),
        .CLK_FREQ (1_600_000),
        .BAUD     (10_000)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_rx_done   (done),
        .o_frame_err (ferr)
    );

    always @(posedge clk) cyc++;

    // Observe pulses on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            rx_q.push_back(data);
            last_done_cyc = cyc;
        end
        if (ferr) ferr_cnt++;
        if (done && ferr) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
        edge_cyc = cyc;
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(b[i], bc);
        hold(stop, bc);
    endtask

    initial begin
        int d0;
        int f0;
        int lat;
        logic [7:0] partial;

        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("rst_data", 32'(data), 32'h00);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ferr", 32'(ferr), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1: single frame, latency window (nominal 1520 + 2 sync, one tick of phase slack)
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, BIT_CYC);
        hold(1'b1, 100);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_byte", 32'(rx_q[d0]), 32'hA5);
        check("t1_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        lat = last_done_cyc - edge_cyc;
        check("t1_latency_in_window", 32'(lat >= 1512 && lat <= 1532), 32'd1);
        check("t1_data_held", 32'(data), 32'hA5);

        // 2: back-to-back frames -> A, B, op
        d0 = done_cnt;
        send_frame(8'h07, 1'b1, BIT_CYC);
        send_frame(8'hF0, 1'b1, BIT_CYC);
        send_frame(8'h3C, 1'b1, BIT_CYC);
        hold(1'b1, 100);
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd3);
        check("t2_op_a", 32'(rx_q[d0]), 32'h07);
        check("t2_op_b", 32'(rx_q[d0+1]), 32'hF0);
        check("t2_opcode", 32'(rx_q[d0+2]), 32'h3C);

        // 3: short glitch rejected at mid start bit
        d0 = done_cnt; f0 = ferr_cnt;
        hold(1'b0, 40);
        hold(1'b1, 300);
        check("t3_glitch_done", 32'(done_cnt - d0), 32'd0);
        check("t3_glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t3_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        send_frame(8'h55, 1'b1, BIT_CYC);
        hold(1'b1, 100);
        check("t3_byte", 32'(rx_q[d0]), 32'h55);

        // 4: low stop bit followed by a long break
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, BIT_CYC);
        hold(1'b0, 1000);
        check("t4_state_break", 32'(dut.state_q), 32'(ST_BREAK));
        hold(1'b0, 1000);
        check("t4_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_data_kept", 32'(data), 32'h55);
        hold(1'b1, 100);
        check("t4_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        send_frame(8'h42, 1'b1, BIT_CYC);
        hold(1'b1, 100);
        check("t4_byte", 32'(rx_q[d0]), 32'h42);

        // 5: reset between the 4th and 5th data bits
        d0 = done_cnt; f0 = ferr_cnt;
        partial = 8'h3C;
        hold(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) hold(partial[i], BIT_CYC);
        rst = 1'b1;
        #1;
        check("t5_rst_data", 32'(data), 32'h00);
        check("t5_rst_done", 32'(done), 32'h0);
        check("t5_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 300);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_frame(8'h99, 1'b1, BIT_CYC);
        hold(1'b1, 100);
        check("t5_byte", 32'(rx_q[d0]), 32'h99);
        check("t5_data_held", 32'(data), 32'h99);

        // 6: +/-3% bit period skew
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, 165);
        hold(1'b1, 300);
        send_frame(8'hFF, 1'b1, 155);
        hold(1'b1, 300);
        check("t6_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("t6_slow_byte", 32'(rx_q[d0]), 32'h00);
        check("t6_fast_byte", 32'(rx_q[d0+1]), 32'hFF);
        check("t6_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);

        check("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
